// File: rtl/dc_axi_mem_responder.sv
// Memory-side responder for the data cache write/refill bus: one pending slot per channel,
// write-first arbitration and programmable access latency over a 128-bit line RAM.
module dc_axi_mem_responder #(
  parameter int AWIDTH = 10,
  parameter int WR_LAT = 4,
  parameter int RD_LAT = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         dcw_start_rq,
  input  logic [31:0]  dcw_in_addr,
  input  logic [15:0]  dcw_in_mask,
  input  logic [127:0] dcw_in_data,
  output logic         dcw_finish_wresp,
  input  logic         dcr_start_rq,
  input  logic [31:0]  dcr_rin_addr,
  output logic [127:0] rdat_m_data,
  output logic         rdat_m_valid,
  output logic         finish_mrd,
  output logic         mem_busy,
  output logic         ovf_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WACC = 3'd1,
    S_WRSP = 3'd2,
    S_RACC = 3'd3,
    S_RDAT = 3'd4,
    S_RFIN = 3'd5
  } state_e;

  localparam int         DEPTH  = 1 << AWIDTH;
  localparam logic [3:0] WR_CNT = 4'(WR_LAT - 1);
  localparam logic [3:0] RD_CNT = 4'(RD_LAT - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [AWIDTH-1:0]   cur_idx_q, cur_idx_d;
  logic [15:0]         cur_mask_q, cur_mask_d;
  logic [127:0]        cur_data_q, cur_data_d;

  logic                wv_q, wv_d;
  logic [AWIDTH-1:0]   widx_q, widx_d;
  logic [15:0]         wmask_q, wmask_d;
  logic [127:0]        wdata_q, wdata_d;
  logic                rv_q, rv_d;
  logic [AWIDTH-1:0]   ridx_q, ridx_d;

  logic                wresp_q, rvalid_q, rfin_q, busy_q, ovf_q;
  logic [127:0]        rdat_q;
  logic [127:0]        mem_q [DEPTH];

  logic                w_take_s, r_take_s, w_ovf_s, r_ovf_s;
  logic                ram_we_s, ram_re_s;
  logic [AWIDTH-1:0]   w_in_idx_s, r_in_idx_s;
  logic                unused_s;

  assign w_in_idx_s = dcw_in_addr[AWIDTH+3:4];
  assign r_in_idx_s = dcr_rin_addr[AWIDTH+3:4];
  assign unused_s   = ^{dcw_in_addr[31:AWIDTH+4], dcw_in_addr[3:0],
                        dcr_rin_addr[31:AWIDTH+4], dcr_rin_addr[3:0]};

  // An IDLE block serves a request straight from the input pulse, so service starts at T0+1.
  always_comb begin
    w_ovf_s  = dcw_start_rq & wv_q;
    r_ovf_s  = dcr_start_rq & rv_q;
    w_take_s = (state_q == S_IDLE) & (wv_q | dcw_start_rq);
    r_take_s = (state_q == S_IDLE) & ~w_take_s & (rv_q | dcr_start_rq);
  end

  always_comb begin
    wv_d    = wv_q;
    widx_d  = widx_q;
    wmask_d = wmask_q;
    wdata_d = wdata_q;
    if (wv_q) begin
      wv_d = ~w_take_s;
    end else if (dcw_start_rq && !w_take_s) begin
      wv_d    = 1'b1;
      widx_d  = w_in_idx_s;
      wmask_d = dcw_in_mask;
      wdata_d = dcw_in_data;
    end else begin
      wv_d = 1'b0;
    end
  end

  always_comb begin
    rv_d   = rv_q;
    ridx_d = ridx_q;
    if (rv_q) begin
      rv_d = ~r_take_s;
    end else if (dcr_start_rq && !r_take_s) begin
      rv_d   = 1'b1;
      ridx_d = r_in_idx_s;
    end else begin
      rv_d = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_idx_d  = cur_idx_q;
    cur_mask_d = cur_mask_q;
    cur_data_d = cur_data_q;
    ram_we_s   = 1'b0;
    ram_re_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_take_s) begin
          state_d = S_WACC;
          cnt_d   = WR_CNT;
          if (wv_q) begin
            cur_idx_d  = widx_q;
            cur_mask_d = wmask_q;
            cur_data_d = wdata_q;
          end else begin
            cur_idx_d  = w_in_idx_s;
            cur_mask_d = dcw_in_mask;
            cur_data_d = dcw_in_data;
          end
        end else if (r_take_s) begin
          state_d   = S_RACC;
          cnt_d     = RD_CNT;
          cur_idx_d = rv_q ? ridx_q : r_in_idx_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WACC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ram_we_s = 1'b1;
          state_d  = S_WRSP;
        end
      end
      S_WRSP: state_d = S_IDLE;
      S_RACC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ram_re_s = 1'b1;
          state_d  = S_RDAT;
        end
      end
      S_RDAT: state_d = S_RFIN;
      S_RFIN: state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Outputs are registered from next-state so each pulse lines up with its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      cur_idx_q  <= '0;
      cur_mask_q <= 16'h0000;
      cur_data_q <= 128'd0;
      wv_q       <= 1'b0;
      widx_q     <= '0;
      wmask_q    <= 16'h0000;
      wdata_q    <= 128'd0;
      rv_q       <= 1'b0;
      ridx_q     <= '0;
      wresp_q    <= 1'b0;
      rvalid_q   <= 1'b0;
      rfin_q     <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      rdat_q     <= 128'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_idx_q  <= cur_idx_d;
      cur_mask_q <= cur_mask_d;
      cur_data_q <= cur_data_d;
      wv_q       <= wv_d;
      widx_q     <= widx_d;
      wmask_q    <= wmask_d;
      wdata_q    <= wdata_d;
      rv_q       <= rv_d;
      ridx_q     <= ridx_d;
      wresp_q    <= (state_d == S_WRSP);
      rvalid_q   <= (state_d == S_RDAT);
      rfin_q     <= (state_d == S_RFIN);
      busy_q     <= (state_d != S_IDLE) | wv_d | rv_d;
      ovf_q      <= ovf_q | w_ovf_s | r_ovf_s;
      if (ram_re_s) begin
        rdat_q <= mem_q[cur_idx_q];
      end
    end
  end

  // Backing RAM is never reset; a cleared mask bit means that byte is written.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      for (int i = 0; i < 16; i++) begin
        if (!cur_mask_q[i]) begin
          mem_q[cur_idx_q][8*i +: 8] <= cur_data_q[8*i +: 8];
        end
      end
    end
  end

  assign dcw_finish_wresp = wresp_q;
  assign rdat_m_data      = rdat_q;
  assign rdat_m_valid     = rvalid_q;
  assign finish_mrd       = rfin_q;
  assign mem_busy         = busy_q;
  assign ovf_err          = ovf_q;

endmodule

// File: doc/dc_axi_mem_responder.md
Name: dc_axi_mem_responder

Overview:
- Memory-side responder for the data cache's tiny AXI write and read bus.
- Accepts single-beat 128-bit line writebacks (`dcw_*`) and line refill reads (`dcr_*`) from the data cache miss/flush logic.
- Serves both from an internal 128-bit-wide backing RAM with programmable access latency.
- Returns write-response and read-data/finish pulses.
- Used as the DDR/SRAM stand-in on FPGA builds and as the bus model in cache regressions.

Parameters:
- AWIDTH, 10, log2 of backing RAM depth in 128-bit lines; line index = addr[AWIDTH+3:4].
- WR_LAT, 4, wait cycles from write acceptance to RAM commit (legal range 1..15).
- RD_LAT, 6, wait cycles from read acceptance to data return (legal range 1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active high
- dcw_start_rq  in  1  write request pulse, 1 cycle
- dcw_in_addr  in  32  write byte address; bits [3:0] ignored
- dcw_in_mask  in  16  byte mask; bit i=1 keeps old byte i, 0 writes it
- dcw_in_data  in  128  write line data
- dcw_finish_wresp  out  1  write response pulse
- dcr_start_rq  in  1  read request pulse, 1 cycle
- dcr_rin_addr  in  32  read byte address; bits [3:0] ignored
- rdat_m_data  out  128  read line data, valid with rdat_m_valid
- rdat_m_valid  out  1  read data valid pulse
- finish_mrd  out  1  read transaction finished pulse
- mem_busy  out  1  state != IDLE or any pending slot occupied
- ovf_err  out  1  sticky: request arrived with its channel slot already pending

Behaviour:
- Reset:
  - All outputs 0, state IDLE, pending slots empty, latency counter 0.
  - RAM contents not reset.
  - rst mid-transaction aborts it; no response pulse is issued; a write not yet committed is dropped.
- Addressing: bits above AWIDTH+3 are ignored, so addresses alias modulo 2^(AWIDTH+4).
- Request capture:
  - Each channel has a one-entry pending slot (address, plus mask and data for writes).
  - A request pulse loads the slot in the cycle it is high, in any state.
  - A request while that channel's slot is already full sets ovf_err and is dropped; the slot keeps its old contents.
  - ovf_err is cleared only by rst.
- Arbitration in IDLE:
  - Write slot wins over read slot, including simultaneous arrival.
  - This guarantees that a dirty writeback lands before the refill of the same line.
- Request timing definitions:
  - Request cycle T0 = the cycle the pulse is high; the pulse is captured at the end of T0.
  - With an empty, IDLE block, service starts at T0+1.
- States:
  - IDLE: write slot full -> WACC, counter = WR_LAT-1, slot freed. Else read slot full -> RACC, counter = RD_LAT-1, slot freed. Else stay.
  - WACC: counter>0 -> decrement. counter==0 -> byte-masked RAM write; dcw_finish_wresp=1 next cycle; -> WRSP.
  - WRSP: dcw_finish_wresp high this single cycle; -> IDLE.
  - RACC: counter>0 -> decrement. counter==0 -> RAM read; -> RDAT.
  - RDAT: rdat_m_valid=1 and rdat_m_data=line for exactly this cycle; -> RFIN.
  - RFIN: finish_mrd=1 for this single cycle; -> IDLE.
- Response timing:
  - dcw_finish_wresp is high in cycle T0+WR_LAT+1.
  - rdat_m_valid is high in cycle T0+RD_LAT+1.
  - finish_mrd is high in cycle T0+RD_LAT+2.
- Serialization: a pending request is serviced only after returning to IDLE, so there is one IDLE cycle between transactions.
- rdat_m_data holds its last value outside RDAT; checkers must qualify it with rdat_m_valid.
- Mask: dcw_in_mask=16'h0000 writes the full line; 16'hFFFF writes nothing but still returns dcw_finish_wresp.
- Read-after-write: a read of a line whose write is pending or in flight returns the post-write data, guaranteed by arbitration order.
- Output pulses are never high for two consecutive cycles.
- Illegal encoding state: -> IDLE.

Test Plan:
- Write/read round trip (RD_LAT=6, WR_LAT=4):
  - Write addr 32'h0000_0120, data 128'h0123…CDEF, mask 0 at T0 -> dcw_finish_wresp high only at T0+5.
  - Read of 32'h0000_0120 at T1 -> rdat_m_valid at T1+7 with the same data, finish_mrd at T1+8.
- Masked write:
  - Preload line 0x40 with all-0xAA.
  - Write all-0x55 with mask 16'h00FF.
  - Read back -> bytes 15..8 = 0x55, bytes 7..0 = 0xAA.
- Simultaneous requests, same line 0x200:
  - Write and read pulsed in the same cycle -> write response first.
  - Read returns the new data; mem_busy high throughout, low one cycle after finish_mrd.
- Overflow:
  - Three reads on consecutive cycles while a read is in RACC -> second is held pending, third sets ovf_err.
  - Only two rdat_m_valid pulses occur; ovf_err stays 1 until rst.
- Aliasing, AWIDTH=10: write at 32'h0001_4010, read at 32'h0000_4010 -> identical data returned.
- Reset mid-read: assert rst during RACC -> no rdat_m_valid or finish_mrd; all outputs 0; next request serviced with nominal latency.
